uart_loader: RTL and testbench

Byte-stream packet parser sitting directly downstream of the UART receiver. Consumes the receiver's `data_out`/`data_rdy` byte pulses and decodes framed load packets (sync, address, length, payload). It packs payload bytes little-endian into 32-bit memory write requests, buffers them in a small FIFO, and issues them on a valid/ready write port toward system memory. This is how program and data images are loaded into the core over the serial link.

---
 rtl/uart_loader_if.sv | 30 +++
 rtl/uart_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader_if
// Description : Byte-stream input and memory write port of the UART loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_loader_if;
  logic [7:0]  data_in;
  logic        data_rdy;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        busy;
  logic        done;
  logic        err;
  logic        overflow;

  modport slave (
    input  data_in, data_rdy, wr_ready,
    output wr_valid, wr_addr, wr_data, wr_strb, busy, done, err, overflow
  );

  modport master (
    output data_in, data_rdy, wr_ready,
    input  wr_valid, wr_addr, wr_data, wr_strb, busy, done, err, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader
// Description : Parses SYNC/ADDR/LEN/payload packets from the UART byte stream
//               into 32-bit memory writes; UART_LOADER_CSUM_EN adds a CSUM byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loader #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FIFO_DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  uart_loader_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic [67:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        w_empty, w_full, w_pop, w_push_ok;
  logic        push, fin;
  logic [67:0] push_word;
  logic [31:0] w_addr_shift;
  logic [15:0] w_len;
  logic [31:0] w_data_ins;
  logic [3:0]  w_strb_ins;

  assign w_empty   = (wptr_q == rptr_q);
  assign w_full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_pop     = !w_empty && bus.wr_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_ok = push && (!w_full || w_pop);

  assign w_addr_shift = {bus.data_in, addr_q[31:8]};
  assign w_len        = {bus.data_in, len_lo_q};
  assign w_strb_ins   = strb_q | (4'b0001 << lane_q);

  always_comb begin
    w_data_ins = data_q;
    w_data_ins[{lane_q, 3'b000} +: 8] = bus.data_in;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    len_lo_d  = len_lo_q;
    rem_d     = rem_q;
    lane_d    = lane_q;
    data_d    = data_q;
    strb_d    = strb_q;
    done_d    = 1'b0;
    err_d     = err_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_word = {addr_q, w_data_ins, w_strb_ins};
    fin       = 1'b0;
`ifdef UART_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif

    if (bus.data_rdy) begin
`ifdef UART_LOADER_CSUM_EN
      if (state_q != S_IDLE && state_q != S_CSUM) begin
        csum_d = csum_q + bus.data_in;
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.data_in == SYNC_BYTE) begin
            state_d = S_ADDR;
            cnt_d   = 2'd0;
            err_d   = 1'b0;
`ifdef UART_LOADER_CSUM_EN
            csum_d  = 8'd0;
`endif
          end
        end
        S_ADDR: begin
          addr_d = w_addr_shift;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            addr_d  = {w_addr_shift[31:2], 2'b00};
            cnt_d   = 2'd0;
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (cnt_q == 2'd0) begin
            len_lo_d = bus.data_in;
            cnt_d    = 2'd1;
          end else begin
            cnt_d  = 2'd0;
            rem_d  = w_len;
            lane_d = 2'd0;
            data_d = 32'd0;
            strb_d = 4'd0;
            if (w_len == 16'd0) begin
              fin = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          data_d = w_data_ins;
          strb_d = w_strb_ins;
          lane_d = lane_q + 2'd1;
          rem_d  = rem_q - 16'd1;
          if (lane_q == 2'd3 || rem_q == 16'd1) begin
            push   = 1'b1;
            addr_d = addr_q + 32'd4;
            data_d = 32'd0;
            strb_d = 4'd0;
            lane_d = 2'd0;
          end
          if (rem_q == 16'd1) begin
            fin = 1'b1;
          end
        end
`ifdef UART_LOADER_CSUM_EN
        S_CSUM: begin
          state_d = S_IDLE;
          if (bus.data_in == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    if (fin) begin
`ifdef UART_LOADER_CSUM_EN
      state_d = S_CSUM;
`else
      state_d = S_IDLE;
      done_d  = 1'b1;
`endif
    end

    if (push && !w_push_ok) begin
      ovf_d = 1'b1;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      addr_q   <= 32'd0;
      len_lo_q <= 8'd0;
      rem_q    <= 16'd0;
      lane_q   <= 2'd0;
      data_q   <= 32'd0;
      strb_q   <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum_q   <= 8'd0;
`endif
      wptr_q   <= '0;
      rptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
`ifdef UART_LOADER_CSUM_EN
      csum_q   <= csum_d;
`endif
      if (w_push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= push_word;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (w_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  assign bus.wr_valid = !w_empty;
  assign {bus.wr_addr, bus.wr_data, bus.wr_strb} = mem_q[rptr_q[AW-1:0]];
  assign bus.busy     = (state_q != S_IDLE) || !w_empty;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loader
// Description : Directed self-checking bench for uart_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [7:0]  cs;
  logic [67:0] wlog [0:63];
  int   wcnt;
  int   done_total;
  int   wb;
  int   db;

  uart_loader_if bus ();

  uart_loader #(.SYNC_BYTE(8'hA5), .FIFO_DEPTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge; accepted writes and done pulses are logged at negedge.
  always @(negedge clk) begin
    if (!rst && bus.wr_valid && bus.wr_ready && wcnt < 64) begin
      wlog[wcnt] <= {bus.wr_addr, bus.wr_data, bus.wr_strb};
      wcnt       <= wcnt + 1;
    end
    if (!rst && bus.done) begin
      done_total <= done_total + 1;
    end
  end

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.data_in  = b;
    bus.data_rdy = 1'b1;
    cs           = cs + b;
    @(posedge clk);
    #1;
    bus.data_rdy = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [15:0] len);
    send(8'hA5);
    cs = 8'd0;
    send(a[7:0]); send(a[15:8]); send(a[23:16]); send(a[31:24]);
    send(len[7:0]); send(len[15:8]);
  endtask

  task automatic send_csum(input logic [7:0] delta);
`ifdef UART_LOADER_CSUM_EN
    send(cs + delta);
`else
    if (delta != 8'd0) cs = cs + delta;
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, " wr_valid"}, {67'd0, bus.wr_valid}, 68'd0);
    check({tag, " wr_word"},  {bus.wr_addr, bus.wr_data, bus.wr_strb}, 68'd0);
    check({tag, " flags"},    {64'd0, bus.busy, bus.done, bus.err, bus.overflow}, 68'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cs = 8'd0;
    wcnt = 0; done_total = 0;
    bus.data_in = 8'd0; bus.data_rdy = 1'b0; bus.wr_ready = 1'b0;
    rst = 1'b1;
    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(2);

    // Basic packet: one full word and one single-byte tail
    bus.wr_ready = 1'b1;
    wb = wcnt; db = done_total;
    send_hdr(32'h0000_1000, 16'd5);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
`ifndef UART_LOADER_CSUM_EN
    check("tail word at done", {bus.wr_addr, bus.wr_data, bus.wr_strb}, {32'h1004, 32'h55, 4'h1});
`endif
    send_csum(8'd0);
    check("done pulse", {66'd0, bus.done, bus.err}, 68'b10);
    tick(1);
    check("done one cycle", {67'd0, bus.done}, 68'd0);
    tick(3);
    check("pkt1 count", wcnt - wb, 2);
    check("pkt1 w0", wlog[wb],     {32'h1000, 32'h4433_2211, 4'hF});
    check("pkt1 w1", wlog[wb + 1], {32'h1004, 32'h0000_0055, 4'h1});
    check("pkt1 done", done_total - db, 1);
    check("idle not busy", {67'd0, bus.busy}, 68'd0);

`ifdef UART_LOADER_CSUM_EN
    // Bad checksum: writes still go out, err instead of done
    wb = wcnt; db = done_total;
    send_hdr(32'h0000_1000, 16'd5);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    send_csum(8'd1);
    check("bad csum err", {67'd0, bus.err}, 68'd1);
    tick(3);
    check("bad csum writes", wcnt - wb, 2);
    check("bad csum no done", done_total - db, 0);
    send(8'hA5);
    check("err cleared at sync", {67'd0, bus.err}, 68'd0);
    cs = 8'd0;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send_csum(8'd0);
    tick(2);
`endif

    // Garbage ignored, LEN=0 gives done only
    wb = wcnt; db = done_total;
    send(8'h00); send(8'hFF); send(8'h3C);
    check("garbage no busy", {66'd0, bus.busy, bus.err}, 68'd0);
    send_hdr(32'h0000_0000, 16'd0);
    send_csum(8'd0);
    tick(3);
    check("len0 no writes", wcnt - wb, 0);
    check("len0 done", done_total - db, 1);

    // Unaligned address is rounded down
    wb = wcnt;
    send_hdr(32'h0000_2003, 16'd4);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send_csum(8'd0);
    tick(3);
    check("unaligned addr", wlog[wb], {32'h2000, 32'hEFBE_ADDE, 4'hF});

    // Address counter wraps past 2^32
    wb = wcnt;
    send_hdr(32'hFFFF_FFFE, 16'd6);
    for (int k = 1; k <= 6; k++) send(8'(k));
    send_csum(8'd0);
    tick(3);
    check("wrap w0", wlog[wb],     {32'hFFFF_FFFC, 32'h0403_0201, 4'hF});
    check("wrap w1", wlog[wb + 1], {32'h0000_0000, 32'h0000_0605, 4'h3});

    // Sink stalled during a 24-byte payload: 4 queued, 2 dropped
    bus.wr_ready = 1'b0;
    wb = wcnt; db = done_total;
    send_hdr(32'h0000_3000, 16'd24);
    for (int k = 1; k <= 24; k++) send(8'(k));
    send_csum(8'd0);
    tick(1);
    check("ovf flags", {66'd0, bus.overflow, bus.err}, 68'b11);
    check("ovf done", done_total - db, 1);
    check("stalled head", {bus.wr_addr, bus.wr_data, bus.wr_strb}, {32'h3000, 32'h0403_0201, 4'hF});
    tick(2);
    check("stalled stable", {bus.wr_addr, bus.wr_data, bus.wr_strb}, {32'h3000, 32'h0403_0201, 4'hF});
    check("stalled busy", {66'd0, bus.wr_valid, bus.busy}, 68'b11);
    bus.wr_ready = 1'b1;
    tick(8);
    check("drain count", wcnt - wb, 4);
    check("drain w0", wlog[wb],     {32'h3000, 32'h0403_0201, 4'hF});
    check("drain w1", wlog[wb + 1], {32'h3004, 32'h0807_0605, 4'hF});
    check("drain w2", wlog[wb + 2], {32'h3008, 32'h0C0B_0A09, 4'hF});
    check("drain w3", wlog[wb + 3], {32'h300C, 32'h100F_0E0D, 4'hF});

    // Reset mid-packet discards state, lanes and sticky flags
    send_hdr(32'h0000_4000, 16'd8);
    send(8'hC1); send(8'hC2); send(8'hC3);
    rst = 1'b1;
    tick(1);
    check_zero("mid reset");
    rst = 1'b0;
    tick(1);
    wb = wcnt;
    send_hdr(32'h0000_5000, 16'd2);
    send(8'h77); send(8'h88);
    send_csum(8'd0);
    tick(3);
    check("post reset count", wcnt - wb, 1);
    check("post reset word", wlog[wb], {32'h5000, 32'h0000_8877, 4'h3});

    // Back-to-back bytes; full FIFO push+pop in one cycle, then toggling ready
    wb = wcnt; db = done_total;
    bus.wr_ready = 1'b0;
    send_hdr(32'h0000_6000, 16'd16);
    for (int k = 0; k < 16; k++) send(8'h60 + 8'(k));
    send_csum(8'd0);
    send_hdr(32'h0000_7000, 16'd8);
    send(8'h70); send(8'h71); send(8'h72);
    bus.wr_ready = 1'b1;
    send(8'h73);
    for (int k = 4; k < 8; k++) begin
      bus.wr_ready = ~bus.wr_ready;
      send(8'h70 + 8'(k));
    end
`ifdef UART_LOADER_CSUM_EN
    bus.wr_ready = ~bus.wr_ready;
    send_csum(8'd0);
`endif
    for (int c = 0; c < 30; c++) begin
      bus.wr_ready = ~bus.wr_ready;
      tick(1);
    end
    check("b2b no overflow", {66'd0, bus.overflow, bus.err}, 68'd0);
    check("b2b count", wcnt - wb, 6);
    check("b2b w0", wlog[wb],     {32'h6000, 32'h6362_6160, 4'hF});
    check("b2b w1", wlog[wb + 1], {32'h6004, 32'h6766_6564, 4'hF});
    check("b2b w2", wlog[wb + 2], {32'h6008, 32'h6B6A_6968, 4'hF});
    check("b2b w3", wlog[wb + 3], {32'h600C, 32'h6F6E_6D6C, 4'hF});
    check("b2b w4", wlog[wb + 4], {32'h7000, 32'h7372_7170, 4'hF});
    check("b2b w5", wlog[wb + 5], {32'h7004, 32'h7776_7574, 4'hF});
    check("b2b done", done_total - db, 2);
    check("b2b drained", {66'd0, bus.wr_valid, bus.busy}, 68'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
